// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side result bundle between uart_rx and the host/FIFO logic.
//   rx_data    last received word, held until the next good frame
//   rx_valid   one-clk strobe: rx_data updated
//   frame_err  one-clk strobe: stop bit sampled low
//   parity_err one-clk strobe: parity mismatch (always 0 unless parity is built in)
//   busy       receiver is inside a frame or waiting out a break
// master = uart_rx (drives), slave = host (observes).
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input parity_err,
        input busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, start + DATA_BITS (LSB first) + stop.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   tick        one-clk pulse at baud * TICKS_PER_BIT; all FSM activity steps on it
//   rx          asynchronous serial input, idle high
//   rx_if       uart_rx_if.master: rx_data / rx_valid / frame_err / parity_err / busy
module uart_rx #(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       rx,
    uart_rx_if.master  rx_if
);
    localparam int unsigned TW = $clog2(TICKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(TICKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_q, parity_bit_d;
    logic                 parity_err_q, parity_err_d;
`endif

    // Two-flop synchronizer runs every clk; its reset value matches the idle line.
    assign sync_d = {sync_q[0], rx};
    assign rx_s   = sync_q[1];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE:   if (!rx_s) state_d = START;
                // A start bit that is high again at its centre was a glitch.
                START:  if (tick_cnt_q == HALF_LAST) state_d = rx_s ? IDLE : DATA;
                DATA: begin
                    if (tick_cnt_q == BIT_LAST && bit_cnt_q == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
                PARITY: if (tick_cnt_q == BIT_LAST) state_d = STOP;
                STOP:   if (tick_cnt_q == BIT_LAST) state_d = rx_s ? IDLE : BREAK;
                // Wait for the line to go high so a held-low line is not read as frames.
                BREAK:  if (rx_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters, shift register and registered output strobes.
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                IDLE: tick_cnt_d = '0;
                START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (tick_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        parity_bit_d = rx_s;
`endif
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = ^{shift_q, parity_bit_q};
`endif
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: tick_cnt_d = '0;
            endcase
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = parity_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx; tick every 4 clks, 64 clks per bit.
module tb_uart_rx;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_CLKS  = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic tick = 1'b0;
    logic rx;
    int   tick_div = 0;

    uart_rx_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx #(.DATA_BITS(DATA_BITS), .TICKS_PER_BIT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .rx    (rx),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    // One-clk tick every 4 clks, changed away from the active edge.
    always @(negedge clk) begin
        tick     = (tick_div == 3);
        tick_div = (tick_div + 1) % 4;
    end

    int errors = 0;
    int checks = 0;

    // Pulse monitor: counts strobes and logs every delivered word.
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         perr_cnt  = 0;
    int         perr_with_valid = 0;
    logic [7:0] log_data [0:15];

    always @(negedge clk) begin
        if (rx_if.rx_valid === 1'b1) begin
            if (valid_cnt < 16) log_data[valid_cnt] = rx_if.rx_data;
            valid_cnt++;
        end
        if (rx_if.frame_err === 1'b1) ferr_cnt++;
        if (rx_if.parity_err === 1'b1) begin
            perr_cnt++;
            if (rx_if.rx_valid === 1'b1) perr_with_valid++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par) begin end
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int clks);
        rx = 1'b1;
        repeat (clks) @(posedge clk);
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_busy",       32'(rx_if.busy),       32'd0);
        check("reset_rx_valid",   32'(rx_if.rx_valid),   32'd0);
        check("reset_rx_data",    32'(rx_if.rx_data),    32'd0);
        check("reset_frame_err",  32'(rx_if.frame_err),  32'd0);
        check("reset_parity_err", 32'(rx_if.parity_err), 32'd0);
        rst_n = 1'b1;
        idle(BIT_CLKS);

        // 1: single good frame 0x55
        send_frame(8'h55, even_par(8'h55), 1'b1);
        idle(BIT_CLKS);
        @(negedge clk);
        check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
        check("t1_data",      32'(log_data[0]), 32'h55);
        check("t1_rx_data",   32'(rx_if.rx_data), 32'h55);
        check("t1_ferr_cnt",  32'(ferr_cnt), 32'd0);
        check("t1_busy",      32'(rx_if.busy), 32'd0);

        // 2: 3-tick low glitch
        rx = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("t2_busy_in_start", 32'(rx_if.busy), 32'd1);
        idle(BIT_CLKS);
        @(negedge clk);
        check("t2_busy_after",  32'(rx_if.busy), 32'd0);
        check("t2_valid_cnt",   32'(valid_cnt), 32'd1);
        check("t2_ferr_cnt",    32'(ferr_cnt), 32'd0);

        // 3: bad stop bit followed by a held-low line
        send_frame(8'h3C, even_par(8'h3C), 1'b0);
        rx = 1'b0;
        repeat (2 * BIT_CLKS) @(posedge clk);
        @(negedge clk);
        check("t3_ferr_cnt",    32'(ferr_cnt), 32'd1);
        check("t3_valid_cnt",   32'(valid_cnt), 32'd1);
        check("t3_rx_data",     32'(rx_if.rx_data), 32'h55);
        check("t3_busy_break",  32'(rx_if.busy), 32'd1);
        idle(BIT_CLKS);
        @(negedge clk);
        check("t3_busy_after",  32'(rx_if.busy), 32'd0);
        check("t3_ferr_final",  32'(ferr_cnt), 32'd1);
        check("t3_valid_final", 32'(valid_cnt), 32'd1);

        // 4: back-to-back 0x00, 0xFF with no idle gap
        send_frame(8'h00, even_par(8'h00), 1'b1);
        send_frame(8'hFF, even_par(8'hFF), 1'b1);
        idle(BIT_CLKS);
        @(negedge clk);
        check("t4_valid_cnt", 32'(valid_cnt), 32'd3);
        check("t4_data0",     32'(log_data[1]), 32'h00);
        check("t4_data1",     32'(log_data[2]), 32'hFF);
        check("t4_ferr_cnt",  32'(ferr_cnt), 32'd1);

        // 5: reset during data bit 4 of 0xA5, then 0x81
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hA5 >> i));
        rx = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t5_busy_mid", 32'(rx_if.busy), 32'd1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_busy_rst",    32'(rx_if.busy), 32'd0);
        check("t5_rx_data_rst", 32'(rx_if.rx_data), 32'd0);
        rst_n = 1'b1;
        idle(2 * BIT_CLKS);
        send_frame(8'h81, even_par(8'h81), 1'b1);
        idle(BIT_CLKS);
        @(negedge clk);
        check("t5_valid_cnt", 32'(valid_cnt), 32'd4);
        check("t5_data",      32'(log_data[3]), 32'h81);
        check("t5_rx_data",   32'(rx_if.rx_data), 32'h81);
        check("t5_ferr_cnt",  32'(ferr_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
        // 6: 0x07 has three ones; parity bit 0 is wrong, 1 is right
        check("t6_perr_before", 32'(perr_cnt), 32'd0);
        send_frame(8'h07, 1'b0, 1'b1);
        idle(BIT_CLKS);
        @(negedge clk);
        check("t6_bad_valid_cnt", 32'(valid_cnt), 32'd5);
        check("t6_bad_data",      32'(log_data[4]), 32'h07);
        check("t6_bad_perr",      32'(perr_with_valid), 32'd1);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(BIT_CLKS);
        @(negedge clk);
        check("t6_good_valid_cnt", 32'(valid_cnt), 32'd6);
        check("t6_good_perr",      32'(perr_cnt), 32'd1);
`else
        check("no_parity_err", 32'(perr_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
